// File: rtl/pwhash_core_if.sv
// Serial-side signal bundle for pwhash_core: UART pair, flow control and
// the entropy source handshake. The host side drives rx/cts/trng_bit.
interface pwhash_core_if;
  logic rx;
  logic cts;
  logic tx;
  logic rts;
  logic trng_bit;
  logic trng_req;

  modport master (
    output rx,
    output cts,
    output trng_bit,
    input  tx,
    input  rts,
    input  trng_req
  );

  modport slave (
    input  rx,
    input  cts,
    input  trng_bit,
    output tx,
    output rts,
    output trng_req
  );
endinterface

// File: rtl/pwhash_core.sv
// Password hashing core: receives a 4-byte password over UART, draws a
// 32-bit salt from a raw TRNG bit, hashes, and returns salt||hash.
// Command 0x02 instead returns one raw random byte.

// Two-flop synchronizer, both stages reset high. The synchronized side is
// int_sig because "int" is a reserved word.
module sync (
  input  logic clk,
  input  logic rst,
  input  logic ext,
  output logic int_sig
);
  logic meta;

  // Two-stage resynchronization into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta    <= 1'b1;
      int_sig <= 1'b1;
    end else begin
      meta    <= ext;
      int_sig <= meta;
    end
  end
endmodule

module pwhash_core #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned TRNG_DIV     = 16
) (
  input  logic          clk,
  input  logic          rst,
  pwhash_core_if.slave  bus
);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int unsigned CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned DW   = (TRNG_DIV > 1) ? $clog2(TRNG_DIV) : 1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic       {TX_IDLE, TX_BUSY} tx_state_t;
  typedef enum logic [2:0] {IDLE, RECV_PW, SALT, HASH, SEND, RAND} state_t;

  logic rx_s, cts_s, trng_s;

  sync u_sync_rx   (.clk(clk), .rst(rst), .ext(bus.rx),       .int_sig(rx_s));
  sync u_sync_cts  (.clk(clk), .rst(rst), .ext(bus.cts),      .int_sig(cts_s));
  sync u_sync_trng (.clk(clk), .rst(rst), .ext(bus.trng_bit), .int_sig(trng_s));

  // ---------------------------------------------------------------- receiver
  rx_state_t      rx_state;
  logic           rx_prev;
  logic [CW-1:0]  rx_cnt;
  logic [2:0]     rx_bit;
  logic [7:0]     rx_shift;
  logic           rx_valid;
  logic [7:0]     rx_data;

  // 8N1 receiver: falling-edge start, mid-bit sampling, bad frames dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_prev  <= 1'b1;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_prev  <= rx_s;
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == CW'(HALF - 1)) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_s) begin
              rx_valid <= 1'b1;
              rx_data  <= rx_shift;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------- transmitter
  tx_state_t      tx_state;
  logic           tx_q;
  logic [8:0]     tx_shift;
  logic [CW-1:0]  tx_cnt;
  logic [3:0]     tx_bitn;
  logic           tx_go;
  logic [7:0]     tx_byte;
  logic           tx_busy;

  assign tx_busy = (tx_state == TX_BUSY);

  // 8N1 transmitter; once loaded a frame always runs to its stop bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_q     <= 1'b1;
      tx_shift <= '0;
      tx_cnt   <= '0;
      tx_bitn  <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          tx_q <= 1'b1;
          if (tx_go) begin
            tx_shift <= {1'b1, tx_byte};
            tx_q     <= 1'b0;
            tx_cnt   <= '0;
            tx_bitn  <= '0;
            tx_state <= TX_BUSY;
          end
        end
        TX_BUSY: begin
          if (tx_cnt == CW'(CLKS_PER_BIT - 1)) begin
            tx_cnt <= '0;
            if (tx_bitn == 4'd9) begin
              tx_q     <= 1'b1;
              tx_state <= TX_IDLE;
            end else begin
              tx_q     <= tx_shift[0];
              tx_shift <= {1'b1, tx_shift[8:1]};
              tx_bitn  <= tx_bitn + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------ control FSM
  state_t         state;
  logic           rts_q;
  logic           trng_req_q;
  logic [1:0]     pw_cnt;
  logic [31:0]    pw_q;
  logic [31:0]    salt;
  logic [31:0]    hash;
  logic [DW-1:0]  div_cnt;
  logic [4:0]     bit_cnt;
  logic [1:0]     round;
  logic [63:0]    out_buf;
  logic [3:0]     send_left;

  function automatic logic [31:0] hash_round(input logic [31:0] h, input logic [7:0] p);
    return ({h[26:0], h[31:27]} ^ {24'h0, p}) + 32'h9E3779B9;
  endfunction

  // Command decode, salt/entropy collection, hashing and response queueing.
  // tx_go is a one-cycle pulse; SEND waits for both it and tx_busy to clear
  // so a byte is never issued twice across the one-cycle load latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rts_q      <= 1'b1;
      trng_req_q <= 1'b0;
      pw_cnt     <= '0;
      pw_q       <= '0;
      salt       <= '0;
      hash       <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      round      <= '0;
      out_buf    <= '0;
      send_left  <= '0;
      tx_go      <= 1'b0;
      tx_byte    <= '0;
    end else begin
      tx_go <= 1'b0;
      case (state)
        IDLE: begin
          rts_q <= 1'b0;
          if (rx_valid) begin
            if (rx_data == 8'h01) begin
              state  <= RECV_PW;
              pw_cnt <= '0;
            end else if (rx_data == 8'h02) begin
              state      <= RAND;
              rts_q      <= 1'b1;
              trng_req_q <= 1'b1;
              salt       <= '0;
              div_cnt    <= '0;
              bit_cnt    <= '0;
            end
          end
        end
        RECV_PW: begin
          if (rx_valid) begin
            pw_q   <= {pw_q[23:0], rx_data};
            pw_cnt <= pw_cnt + 1'b1;
            if (pw_cnt == 2'd3) begin
              state      <= SALT;
              rts_q      <= 1'b1;
              trng_req_q <= 1'b1;
              salt       <= '0;
              div_cnt    <= '0;
              bit_cnt    <= '0;
            end
          end
        end
        SALT: begin
          if (div_cnt == DW'(TRNG_DIV - 1)) begin
            div_cnt <= '0;
            salt    <= {salt[30:0], trng_s};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 5'd31) begin
              trng_req_q <= 1'b0;
              hash       <= {salt[30:0], trng_s};
              round      <= '0;
              state      <= HASH;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HASH: begin
          hash  <= hash_round(hash, pw_q[31:24]);
          pw_q  <= {pw_q[23:0], 8'h00};
          round <= round + 1'b1;
          if (round == 2'd3) begin
            out_buf   <= {salt, hash_round(hash, pw_q[31:24])};
            send_left <= 4'd8;
            state     <= SEND;
          end
        end
        RAND: begin
          if (div_cnt == DW'(TRNG_DIV - 1)) begin
            div_cnt <= '0;
            salt    <= {salt[30:0], trng_s};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 5'd7) begin
              trng_req_q <= 1'b0;
              out_buf    <= {salt[6:0], trng_s, 56'h0};
              send_left  <= 4'd1;
              state      <= SEND;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SEND: begin
          if (!tx_go && !tx_busy) begin
            if (send_left != '0) begin
              if (!cts_s) begin
                tx_go     <= 1'b1;
                tx_byte   <= out_buf[63:56];
                out_buf   <= {out_buf[55:0], 8'h00};
                send_left <= send_left - 1'b1;
              end
            end else begin
              state <= IDLE;
              rts_q <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          rts_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx       = tx_q;
  assign bus.rts      = rts_q;
  assign bus.trng_req = trng_req_q;
endmodule

// File: tb/tb_pwhash_core.sv
// Directed bench for pwhash_core with a UART monitor feeding a scoreboard.
module tb_pwhash_core;
  localparam int unsigned CPB = 8;
  localparam int unsigned TD  = 4;

  logic clk = 1'b0;
  logic rst;
  pwhash_core_if bus();

  pwhash_core #(.CLKS_PER_BIT(CPB), .TRNG_DIV(TD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  int frames   = 0;
  int trng_hi  = 0;
  int tx_lo    = 0;
  int rts_hi   = 0;
  logic mon_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Activity counters sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.trng_req === 1'b1) trng_hi++;
    if (bus.tx === 1'b0)       tx_lo++;
    if (bus.rts === 1'b1)      rts_hi++;
  end

  // UART monitor: decode each tx frame and check it against the scoreboard.
  logic [7:0] mon_byte;
  logic       mon_stop;
  logic       mon_abort;
  initial begin : monitor
    forever begin
      @(negedge bus.tx);
      if (rst) continue;
      mon_busy  = 1'b1;
      mon_abort = 1'b0;
      for (int i = 0; i < int'(CPB / 2); i++) begin
        @(negedge clk);
        if (rst) mon_abort = 1'b1;
      end
      for (int b = 0; b < 9; b++) begin
        for (int i = 0; i < int'(CPB); i++) begin
          @(negedge clk);
          if (rst) mon_abort = 1'b1;
        end
        if (b < 8) mon_byte[b] = bus.tx;
        else       mon_stop    = bus.tx;
      end
      if (!mon_abort) begin
        frames++;
        chk("stop_bit", 32'(mon_stop), 32'd1);
        n_assert++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL unexpected_byte: observed %0h expected none", mon_byte);
        end
        if (exp_q.size() != 0) chk("resp_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
      end
      mon_busy = 1'b0;
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_hash(input logic [31:0] s, input logic [7:0] p0,
                                            input logic [7:0] p1, input logic [7:0] p2,
                                            input logic [7:0] p3);
    logic [31:0] h;
    logic [7:0]  p[4];
    p = '{p0, p1, p2, p3};
    h = s;
    for (int i = 0; i < 4; i++)
      h = (((h << 5) | (h >> 27)) ^ 32'(p[i])) + 32'h9E3779B9;
    return h;
  endfunction

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      bus.rx = fr[i];
      repeat (CPB - 1) @(posedge clk);
    end
    @(posedge clk);
    bus.rx = 1'b1;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send_pw(input logic [7:0] p0, input logic [7:0] p1,
                         input logic [7:0] p2, input logic [7:0] p3);
    uart_send(8'h01, 1'b1);
    uart_send(p0, 1'b1);
    uart_send(p1, 1'b1);
    uart_send(p2, 1'b1);
    uart_send(p3, 1'b1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 6000; i++) begin
      if (exp_q.size() == 0 && !mon_busy && bus.rts === 1'b0) break;
      @(negedge clk);
    end
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_rts_idle"}, 32'(bus.rts), 32'd0);
  endtask

  initial begin : stimulus
    int t0, f0, r0, l0;
    logic found;
    rst = 1'b1;
    bus.rx = 1'b1;
    bus.cts = 1'b0;
    bus.trng_bit = 1'b0;

    // Reset state
    repeat (5) @(posedge clk);
    #1;
    chk("rst_tx", 32'(bus.tx), 32'd1);
    chk("rst_rts", 32'(bus.rts), 32'd1);
    chk("rst_trng_req", 32'(bus.trng_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_rts", 32'(bus.rts), 32'd0);
    chk("post_rst_tx", 32'(bus.tx), 32'd1);

    // Zero salt, zero password: fixed reference response
    bus.trng_bit = 1'b0;
    t0 = trng_hi;
    push_word(32'h00000000);
    push_word(32'hFFEA6261);
    send_pw(8'h00, 8'h00, 8'h00, 8'h00);
    chk("salt_rts_high", 32'(bus.rts), 32'd1);
    chk("salt_trng_req", 32'(bus.trng_req), 32'd1);
    wait_done("zero_pw");
    chk("zero_trng_len", 32'(trng_hi - t0), 32'(32 * TD));

    // All-ones salt with a mixed password
    bus.trng_bit = 1'b1;
    t0 = trng_hi;
    push_word(32'hFFFFFFFF);
    push_word(model_hash(32'hFFFFFFFF, 8'h12, 8'h34, 8'h56, 8'h78));
    send_pw(8'h12, 8'h34, 8'h56, 8'h78);
    wait_done("ones_pw");
    chk("ones_trng_len", 32'(trng_hi - t0), 32'(32 * TD));

    // Random-byte command, then an unknown command
    t0 = trng_hi;
    exp_q.push_back(8'hFF);
    uart_send(8'h02, 1'b1);
    wait_done("rand");
    chk("rand_trng_len", 32'(trng_hi - t0), 32'(8 * TD));
    f0 = frames;
    r0 = rts_hi;
    uart_send(8'h7E, 1'b1);
    repeat (20 * CPB) @(posedge clk);
    chk("unknown_no_resp", 32'(frames - f0), 32'd0);
    chk("unknown_rts_low", 32'(rts_hi - r0), 32'd0);

    // Flow control: cts held high stalls the response
    bus.cts = 1'b1;
    bus.trng_bit = 1'b0;
    push_word(32'h00000000);
    push_word(model_hash(32'h00000000, 8'hA5, 8'h5A, 8'h01, 8'h02));
    send_pw(8'hA5, 8'h5A, 8'h01, 8'h02);
    l0 = tx_lo;
    f0 = frames;
    repeat (64 * TD + 200) @(posedge clk);
    #1;
    chk("cts_tx_quiet", 32'(tx_lo - l0), 32'd0);
    chk("cts_no_frames", 32'(frames - f0), 32'd0);
    chk("cts_rts_high", 32'(bus.rts), 32'd1);
    bus.cts = 1'b0;
    wait_done("cts_release");
    chk("cts_all_bytes", 32'(frames - f0), 32'd8);

    // Framing error in IDLE is ignored, next valid command is served
    bus.trng_bit = 1'b1;
    f0 = frames;
    uart_send(8'h02, 1'b0);
    repeat (20 * CPB) @(posedge clk);
    #1;
    chk("bad_stop_no_resp", 32'(frames - f0), 32'd0);
    chk("bad_stop_rts_low", 32'(bus.rts), 32'd0);
    exp_q.push_back(8'hFF);
    uart_send(8'h02, 1'b1);
    wait_done("after_bad_stop");

    // Reset in the middle of a response frame
    bus.trng_bit = 1'b0;
    push_word(32'h00000000);
    push_word(model_hash(32'h00000000, 8'h11, 8'h22, 8'h33, 8'h44));
    send_pw(8'h11, 8'h22, 8'h33, 8'h44);
    found = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (bus.tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    chk("send_started", 32'(found), 32'd1);
    repeat (3 * CPB) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midsend_rst_tx", 32'(bus.tx), 32'd1);
    chk("midsend_rst_rts", 32'(bus.rts), 32'd1);
    exp_q.delete();
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("release_rts", 32'(bus.rts), 32'd0);
    chk("release_tx", 32'(bus.tx), 32'd1);
    f0 = frames;
    l0 = tx_lo;
    repeat (30 * CPB) @(posedge clk);
    chk("no_resume_frames", 32'(frames - f0), 32'd0);
    chk("no_resume_tx", 32'(tx_lo - l0), 32'd0);
    bus.trng_bit = 1'b1;
    exp_q.push_back(8'hFF);
    uart_send(8'h02, 1'b1);
    wait_done("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pwhash_core.md
PWHASH_CORE -- requirements
Module: pwhash_core

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, meaning clock cycles per UART bit (12 MHz at 115200 baud).
REQ-002 SHALL have parameter TRNG_DIV, default 16, meaning clock cycles per sampled TRNG bit.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port: clk  input  1  sole clock; all flops on its rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: rx  input  1  asynchronous UART receive line, 8N1, idle high.
REQ-007 Port: cts  input  1  asynchronous clear-to-send; low means the host accepts data.
REQ-008 Port: tx  output  1  UART transmit line, 8N1, idle high.
REQ-009 Port: rts  output  1  ready-to-send; low means the core accepts a byte.
REQ-010 Port: trng_bit  input  1  asynchronous raw entropy bit.
REQ-011 Port: trng_req  output  1  high while entropy is being collected.

Function
REQ-012 rx, cts and trng_bit SHALL each pass through a separate instance of a two-flop synchronizer submodule named sync (ports clk, rst, ext, int); both flops reset to 1.
REQ-013 UART receiver SHALL detect a falling edge on synchronized rx and sample at mid-bit (CLKS_PER_BIT/2 after the edge, then every CLKS_PER_BIT), data LSB first.
REQ-014 Receiver SHALL discard a byte whose start bit is not 0 at mid-bit or whose stop bit is 0.
REQ-015 Transmitter SHALL send start 0, 8 data bits LSB first, stop 1, each bit CLKS_PER_BIT cycles.
REQ-016 Transmitter SHALL start a byte only when synchronized cts is 0; a byte already started always completes.
REQ-017 rts SHALL be 0 only in states IDLE and RECV_PW; it SHALL be 1 in all other states.
REQ-018 FSM states: IDLE, RECV_PW, SALT, HASH, SEND, RAND.
REQ-019 IDLE: byte 0x01 -> RECV_PW with byte count cleared; byte 0x02 -> RAND; any other byte is ignored.
REQ-020 RECV_PW SHALL collect exactly 4 password bytes P0..P3, then go to SALT.
REQ-021 SALT SHALL hold trng_req=1 and, every TRNG_DIV cycles, shift the synchronized trng_bit in as salt <= {salt[30:0], bit}.
REQ-022 After 32 salt bits, SALT SHALL drop trng_req and go to HASH.
REQ-023 HASH: h = salt; for i = 0..3, one round per clock: h = (rotl(h,5) XOR {24'h0,Pi}) + 32'h9E3779B9, mod 2^32.
REQ-024 After HASH completes, SEND SHALL transmit 8 bytes: salt[31:24], salt[23:16], salt[15:8], salt[7:0], h[31:24], h[23:16], h[15:8], h[7:0], then return to IDLE.
REQ-025 RAND SHALL collect 8 TRNG bits per REQ-021, transmit that one byte, then return to IDLE.
REQ-026 Bytes received outside IDLE and RECV_PW SHALL be dropped.
REQ-027 There SHALL be no timeout; a partial password waits indefinitely.

Reset
REQ-028 While rst=1: tx=1, rts=1, trng_req=0, FSM=IDLE, and salt, hash, counters and synchronizer flops cleared (synchronizers to 1); this takes effect immediately, independent of clk.
REQ-029 After rst falls, the first cycle SHALL give rts=0 and tx=1.
REQ-030 Reset mid-operation SHALL abort any transfer at once; tx SHALL go high with no partial frame resumed.

Verification
REQ-031 trng_bit=0, cts=0, send 01 00 00 00 00 -> tx returns 00 00 00 00 FF EA 62 61.
REQ-032 trng_bit=1, send 01 then four password bytes -> first four response bytes FF FF FF FF; trng_req high for 32*TRNG_DIV cycles.
REQ-033 trng_bit=1, send 02 -> single response byte FF; send 7E -> no response and rts stays 0.
REQ-034 Hold cts=1 during SEND -> tx stays high; release cts -> all 8 bytes follow.
REQ-035 Frame with stop bit 0 while in IDLE -> byte ignored; a following valid 02 is still served.
REQ-036 Assert rst mid-SEND -> tx=1, rts=1 immediately; after release, core is IDLE with rts=0.
